rcu_xfer_sched: RTL and testbench

Sequencer for the RCU byte datapath between the 32-bit AHB word side and the 8-bit controller side.
- Host write (hwrite=1, TX): unpacks captured 32-bit words into bytes, LSB first, toward the controller. Stops at the EOT marker byte.
- Host read (hwrite=0, RX): packs controller bytes into 32-bit words toward the AHB side.
- Owns the transfer FSM, byte count, EOT signalling and limit error.

---
 rtl/rcu_pkg.sv | 18 +
 rtl/rcu_xfer_sched_if.sv | 43 ++++
 rtl/rcu_byte_counter.sv | 30 +++
 rtl/rcu_xfer_sched.sv | 174 +++++++++++++++++
 tb/tb_rcu_xfer_sched.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rcu_pkg.sv
// Shared types and constants for the RCU byte-datapath sequencers.
package rcu_pkg;

  localparam int unsigned RCU_LANES    = 4;
  localparam logic [7:0]  RCU_EOT_BYTE = 8'hFF;

  typedef logic [1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE,
    TX_LOAD,
    TX_BYTE,
    RX_PACK,
    RX_PUSH,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/rcu_xfer_sched_if.sv
// Control, word-side and byte-side signals of the transfer sequencer.
interface rcu_xfer_sched_if #(
  parameter int unsigned MAX_BYTES = 64
);
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);

  logic          start;
  logic          hwrite;
  logic          abort;
  logic [31:0]   tx_word;
  logic          tx_word_valid;
  logic          tx_word_ready;
  logic [7:0]    byte_out;
  logic          byte_out_valid;
  logic          byte_out_ready;
  logic [7:0]    byte_in;
  logic          byte_in_valid;
  logic          byte_in_last;
  logic          byte_in_ready;
  logic [31:0]   rx_word;
  logic          rx_word_valid;
  logic          rx_word_ready;
  logic [2:0]    rx_word_bytes;
  logic          busy;
  logic          eot;
  logic          err;
  logic [CW-1:0] byte_count;

  modport master (
    output start, hwrite, abort, tx_word, tx_word_valid, byte_out_ready,
           byte_in, byte_in_valid, byte_in_last, rx_word_ready,
    input  tx_word_ready, byte_out, byte_out_valid, byte_in_ready,
           rx_word, rx_word_valid, rx_word_bytes, busy, eot, err, byte_count
  );

  modport slave (
    input  start, hwrite, abort, tx_word, tx_word_valid, byte_out_ready,
           byte_in, byte_in_valid, byte_in_last, rx_word_ready,
    output tx_word_ready, byte_out, byte_out_valid, byte_in_ready,
           rx_word, rx_word_valid, rx_word_bytes, busy, eot, err, byte_count
  );

endinterface

// File: rtl/rcu_byte_counter.sv
// Per-transfer byte counter with limit detection, shared by RCU sequencers.
module rcu_byte_counter #(
  parameter  int unsigned MAX_BYTES = 64,
  localparam int unsigned CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_limit_c,
  output logic          hit_next_c
);

  // Count register: clear wins over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // Limit already reached, and limit reached by the next increment
  assign at_limit_c = (count == CW'(MAX_BYTES));
  assign hit_next_c = (count == CW'(MAX_BYTES - 1));

endmodule

// File: rtl/rcu_xfer_sched.sv
// Transfer sequencer: unpacks host words to bytes (TX), packs bytes to words (RX).
module rcu_xfer_sched
  import rcu_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64,
  parameter logic [7:0]  EOT_BYTE  = RCU_EOT_BYTE
) (
  input logic              clk,
  input logic              rst,
  rcu_xfer_sched_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_BYTES + 1);

  xfer_state_t   state_q, state_d;
  lane_t         lane_q, lane_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   pack_q, pack_d;
  logic [2:0]    rxb_q, rxb_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          busy_q, eot_q;
  logic          cnt_clr, cnt_inc;
  logic [CW-1:0] count;
  logic          at_limit_c, hit_next_c;
  logic          tw_rdy_c, bo_vld_c, bi_rdy_c, rw_vld_c;
  logic          tx_hs_c, bo_hs_c, bi_hs_c, rw_hs_c;

  rcu_byte_counter #(.MAX_BYTES(MAX_BYTES)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (count),
    .at_limit_c (at_limit_c),
    .hit_next_c (hit_next_c)
  );

  // Ready/valid per state; abort masks them all in the same cycle
  assign tw_rdy_c = (state_q == TX_LOAD) && !bus.abort;
  assign bo_vld_c = (state_q == TX_BYTE) && !bus.abort;
  assign bi_rdy_c = (state_q == RX_PACK) && !bus.abort;
  assign rw_vld_c = (state_q == RX_PUSH) && !bus.abort;

  assign tx_hs_c = tw_rdy_c && bus.tx_word_valid;
  assign bo_hs_c = bo_vld_c && bus.byte_out_ready;
  assign bi_hs_c = bi_rdy_c && bus.byte_in_valid;
  assign rw_hs_c = rw_vld_c && bus.rx_word_ready;

  // Next-state, datapath and counter control
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    pack_d  = pack_q;
    rxb_d   = rxb_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_clr = 1'b1;
          err_d   = 1'b0;
          lane_d  = '0;
          pack_d  = '0;
          last_d  = 1'b0;
          state_d = bus.hwrite ? TX_LOAD : RX_PACK;
        end
      end
      TX_LOAD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (tx_hs_c) begin
          shift_d = bus.tx_word;
          lane_d  = '0;
          state_d = TX_BYTE;
        end
      end
      TX_BYTE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bo_hs_c) begin
          cnt_inc = 1'b1;
          if (shift_q[7:0] == EOT_BYTE) begin
            state_d = DONE;
          end else if (hit_next_c) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (lane_q == lane_t'(RCU_LANES - 1)) begin
            state_d = TX_LOAD;
          end else begin
            shift_d = shift_q >> 8;
            lane_d  = lane_q + lane_t'(1);
          end
        end
      end
      RX_PACK: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bi_hs_c) begin
          cnt_inc = 1'b1;
          pack_d[{lane_q, 3'b000} +: 8] = bus.byte_in;
          last_d  = bus.byte_in_last;
          if (lane_q == lane_t'(RCU_LANES - 1) || bus.byte_in_last || hit_next_c) begin
            rxb_d   = 3'(lane_q) + 3'd1;
            state_d = RX_PUSH;
          end else begin
            lane_d = lane_q + lane_t'(1);
          end
        end
      end
      RX_PUSH: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rw_hs_c) begin
          if (last_q || at_limit_c) begin
            err_d   = !last_q;
            state_d = DONE;
          end else begin
            pack_d  = '0;
            lane_d  = '0;
            state_d = RX_PACK;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      shift_q <= '0;
      pack_q  <= '0;
      rxb_q   <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      eot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      pack_q  <= pack_d;
      rxb_q   <= rxb_d;
      err_q   <= err_d;
      last_q  <= last_d;
      busy_q  <= (state_d != IDLE);
      eot_q   <= (state_d == DONE);
    end
  end

  assign bus.tx_word_ready  = tw_rdy_c;
  assign bus.byte_out_valid = bo_vld_c;
  assign bus.byte_in_ready  = bi_rdy_c;
  assign bus.rx_word_valid  = rw_vld_c;
  assign bus.byte_out       = shift_q[7:0];
  assign bus.rx_word        = pack_q;
  assign bus.rx_word_bytes  = rxb_q;
  assign bus.busy           = busy_q;
  assign bus.eot            = eot_q;
  assign bus.err            = err_q;
  assign bus.byte_count     = count;

endmodule

// File: tb/tb_rcu_xfer_sched.sv
// Self-checking bench for rcu_xfer_sched: directed cases plus random transfers.
module tb_rcu_xfer_sched;

  localparam int unsigned MAXB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rcu_xfer_sched_if #(.MAX_BYTES(MAXB)) bus ();

  rcu_xfer_sched #(.MAX_BYTES(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] tw[$];
  logic [7:0]  rb[$];
  logic [7:0]  got_b[$], exp_b[$];
  logic [31:0] got_w[$], exp_w[$];
  logic [2:0]  got_n[$], exp_n[$];
  bit          exp_err;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_out"}, 32'(bus.byte_out), 0);
    chk({tag, "_rx_word"}, bus.rx_word, 0);
    chk({tag, "_rx_bytes"}, 32'(bus.rx_word_bytes), 0);
    chk({tag, "_handshakes"}, 32'({bus.tx_word_ready, bus.byte_out_valid,
                                   bus.byte_in_ready, bus.rx_word_valid}), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_eot"}, 32'(bus.eot), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_count"}, 32'(bus.byte_count), 0);
  endtask

  // Byte stream the controller should see: LSB-first, ending at FF or at the limit
  function automatic void model_tx();
    bit stop;
    logic [7:0] b;
    stop = 0;
    exp_b.delete();
    exp_err = 0;
    for (int i = 0; i < tw.size() && !stop; i++) begin
      for (int k = 0; k < 4 && !stop; k++) begin
        b = tw[i][8*k +: 8];
        exp_b.push_back(b);
        if (b == 8'hFF) stop = 1;
        else if (exp_b.size() == MAXB) begin stop = 1; exp_err = 1; end
      end
    end
    exp_cnt = exp_b.size();
  endfunction

  // Words the host should see: groups of four accepted bytes, zero-filled
  function automatic void model_rx();
    int n, c;
    logic [31:0] w;
    exp_w.delete();
    exp_n.delete();
    n = (rb.size() < MAXB) ? rb.size() : MAXB;
    exp_err = (rb.size() > MAXB);
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      c = 0;
      for (int k = 0; k < 4 && i + k < n; k++) begin
        w[8*k +: 8] = rb[i+k];
        c++;
      end
      exp_w.push_back(w);
      exp_n.push_back(3'(c));
    end
    exp_cnt = n;
  endfunction

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
  endfunction

  function automatic bit pick_ready(input int mode, input int cyc, input int lo, input int hi);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 2) != 0);
    return !(cyc >= lo && cyc < hi);
  endfunction

  // mode 0: always ready, 1: random, 2: ready low during cycles [lo,hi)
  task automatic run_tx(input int mode, input int lo, input int hi, input int abort_after);
    int wi, cyc;
    bit done, aborted, hs, held;
    logic [7:0] held_b;
    wi = 0; cyc = 0; done = 0; aborted = 0; held = 0; held_b = '0;
    model_tx();
    got_b.delete();
    bus.hwrite = 1'b1;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    chk("tx_start_busy", 32'(bus.busy), 1);
    chk("tx_start_count", 32'(bus.byte_count), 0);
    chk("tx_start_err", 32'(bus.err), 0);
    while (!done && cyc < 500) begin
      bus.tx_word_valid  = (wi < tw.size());
      bus.tx_word        = (wi < tw.size()) ? tw[wi] : '0;
      bus.byte_out_ready = pick_ready(mode, cyc, lo, hi);
      bus.start          = (mode == 1) && ($urandom_range(0, 7) == 0);
      bus.hwrite         = 1'($urandom_range(0, 1));
      bus.abort          = (abort_after >= 0) && (got_b.size() == abort_after);
      #1;
      if (held) begin
        chk("tx_hold_valid", 32'(bus.byte_out_valid), 32'(!bus.abort));
        if (!bus.abort) chk("tx_hold_data", 32'(bus.byte_out), 32'(held_b));
      end
      if (bus.abort) begin
        chk("abort_masks", 32'(bus.byte_out_valid | bus.tx_word_ready), 0);
        aborted = 1;
      end
      hs = bus.byte_out_valid && bus.byte_out_ready;
      if (hs) got_b.push_back(bus.byte_out);
      held   = bus.byte_out_valid && !bus.byte_out_ready;
      held_b = bus.byte_out;
      if (bus.tx_word_valid && bus.tx_word_ready) wi++;
      step();
      cyc++;
      if (aborted) begin
        done = 1;
      end else begin
        chk("tx_busy", 32'(bus.busy), 1);
        chk("tx_count", 32'(bus.byte_count), 32'(got_b.size()));
        if (bus.eot) begin
          done = 1;
          chk("tx_eot_timing", 32'(hs && got_b.size() == exp_b.size()), 1);
        end
      end
    end
    bus.abort = 1'b0; bus.start = 1'b0; bus.tx_word_valid = 1'b0; bus.byte_out_ready = 1'b0;
    chk("tx_terminated", 32'(done), 1);
    if (aborted) begin
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_eot", 32'(bus.eot), 0);
      chk("abort_count", 32'(bus.byte_count), 32'(abort_after));
      chk("abort_err", 32'(bus.err), 0);
      for (int i = 0; i < got_b.size(); i++) chk("abort_byte", 32'(got_b[i]), 32'(exp_b[i]));
    end else begin
      chk("tx_nbytes", 32'(got_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
        chk("tx_byte", 32'(got_b[i]), 32'(exp_b[i]));
      chk("tx_err", 32'(bus.err), 32'(exp_err));
      step();
      chk("tx_eot_once", 32'(bus.eot), 0);
      chk("tx_idle_busy", 32'(bus.busy), 0);
      chk("tx_final_count", 32'(bus.byte_count), 32'(exp_cnt));
      chk("tx_err_sticky", 32'(bus.err), 32'(exp_err));
    end
  endtask

  task automatic run_rx(input int mode, input int lo, input int hi);
    int bi, cyc;
    bit done, hs, bvalid, held;
    logic [31:0] held_w;
    logic [2:0]  held_n;
    bi = 0; cyc = 0; done = 0; bvalid = 0; held = 0; held_w = '0; held_n = '0;
    model_rx();
    got_w.delete();
    got_n.delete();
    bus.hwrite = 1'b0;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rx_start_busy", 32'(bus.busy), 1);
    chk("rx_start_count", 32'(bus.byte_count), 0);
    chk("rx_start_err", 32'(bus.err), 0);
    while (!done && cyc < 500) begin
      if (!bvalid) bvalid = (bi < rb.size()) && (mode != 1 || $urandom_range(0, 3) != 0);
      bus.byte_in_valid = bvalid;
      bus.byte_in       = (bi < rb.size()) ? rb[bi] : '0;
      bus.byte_in_last  = (bi == rb.size() - 1);
      bus.rx_word_ready = pick_ready(mode, cyc, lo, hi);
      bus.start         = (mode == 1) && ($urandom_range(0, 7) == 0);
      bus.hwrite        = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        chk("rx_hold_valid", 32'(bus.rx_word_valid), 1);
        chk("rx_hold_data", bus.rx_word, held_w);
        chk("rx_hold_bytes", 32'(bus.rx_word_bytes), 32'(held_n));
      end
      if (bvalid && bus.byte_in_ready) begin bi++; bvalid = 0; end
      hs = bus.rx_word_valid && bus.rx_word_ready;
      if (hs) begin got_w.push_back(bus.rx_word); got_n.push_back(bus.rx_word_bytes); end
      held   = bus.rx_word_valid && !bus.rx_word_ready;
      held_w = bus.rx_word;
      held_n = bus.rx_word_bytes;
      step();
      cyc++;
      chk("rx_busy", 32'(bus.busy), 1);
      chk("rx_count", 32'(bus.byte_count), 32'(bi));
      if (bus.eot) begin
        done = 1;
        chk("rx_eot_timing", 32'(hs && got_w.size() == exp_w.size()), 1);
      end
    end
    bus.start = 1'b0; bus.byte_in_valid = 1'b0; bus.byte_in_last = 1'b0; bus.rx_word_ready = 1'b0;
    chk("rx_terminated", 32'(done), 1);
    chk("rx_nwords", 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      chk("rx_word", got_w[i], exp_w[i]);
      chk("rx_word_bytes", 32'(got_n[i]), 32'(exp_n[i]));
    end
    chk("rx_err", 32'(bus.err), 32'(exp_err));
    step();
    chk("rx_eot_once", 32'(bus.eot), 0);
    chk("rx_idle_busy", 32'(bus.busy), 0);
    chk("rx_final_count", 32'(bus.byte_count), 32'(exp_cnt));
    chk("rx_err_sticky", 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.hwrite = 1'b0; bus.abort = 1'b0;
    bus.tx_word = '0; bus.tx_word_valid = 1'b0; bus.byte_out_ready = 1'b0;
    bus.byte_in = '0; bus.byte_in_valid = 1'b0; bus.byte_in_last = 1'b0;
    bus.rx_word_ready = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // TX basic: stops at FF, trailing 00 never sent
    tw = '{32'h44332211, 32'h00FF6655};
    run_tx(0, 0, 0, -1);

    // RX pack: five bytes, last on the fifth
    rb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_rx(0, 0, 0);

    // Backpressure on both sides
    tw = '{32'h14131211, 32'hFF171615};
    run_tx(2, 3, 8, -1);
    rb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    run_rx(2, 4, 7);

    // Limit: TX without terminator, RX with last on the limit byte, RX past the limit
    tw = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    run_tx(0, 0, 0, -1);
    rb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_rx(0, 0, 0);
    rb = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
    run_rx(0, 0, 0);

    // Abort after two TX bytes, then a clean transfer
    tw = '{32'h44332211, 32'h00FF6655};
    run_tx(0, 0, 0, 2);
    run_tx(0, 0, 0, -1);

    // start together with abort in IDLE stays idle
    bus.start = 1'b1; bus.abort = 1'b1; bus.hwrite = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", 32'(bus.busy), 0);

    // Reset while a packed word waits in RX_PUSH
    bus.hwrite = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.rx_word_ready = 1'b0; bus.byte_in_valid = 1'b1; bus.byte_in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.byte_in = 8'hB0 + 8'(i);
      step();
    end
    bus.byte_in_valid = 1'b0;
    #1;
    chk("push_reached", 32'(bus.rx_word_valid), 1);
    chk("push_word", bus.rx_word, 32'hB3B2B1B0);
    rst = 1'b1;
    step();
    chk_all_zero("mid_reset");
    rst = 1'b0;
    step();

    // Random transfers with random backpressure and stray start pulses
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        tw.delete();
        for (int i = 0; i < 3; i++)
          tw.push_back({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()});
        run_tx(1, 0, 0, -1);
      end else begin
        rb.delete();
        for (int i = 0; i < int'($urandom_range(1, 12)); i++) rb.push_back(8'($urandom_range(0, 255)));
        run_rx(1, 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
